// File: rtl/eth_traffic_sequencer.sv
// Burst-test sequencer for the TX side of ethernet_interface_top.
// It latches a run configuration and sends N frames using the tx_start/tx_fsm_busy
// handshake. Frames are separated by a programmable idle gap, and the payload size
// can be swept between runs of frames. At the end it waits for the RX counter to
// account for every frame and reports pass/fail with an error code.
//
// Ports:
//   i_main_clk, i_rst          clock, asynchronous active-high reset
//   i_run, i_abort             start pulse (IDLE/DONE only), abort level
//   i_num_packets .. i_timeout run configuration, latched on an accepted run
//   i_tx_fsm_busy              core TX busy
//   i_rx_packet_count          core RX frame counter (wraps)
//   o_tx_start .. o_lfsr_seed  core control, all registered
//   o_busy, o_done, o_pass     run status
//   o_err_code                 0 ok, 1 start timeout, 2 end timeout,
//                              3 drain timeout, 4 abort
//   o_tx_sent, o_rx_seen       frame counters for the current run
module eth_traffic_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RXC_W = 10
) (
  input  logic             i_main_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_num_packets,
  input  logic [15:0]      i_payload_min,
  input  logic [15:0]      i_payload_max,
  input  logic [15:0]      i_payload_step,
  input  logic             i_use_lfsr,
  input  logic [31:0]      i_lfsr_seed,
  input  logic [15:0]      i_gap_count,
  input  logic [CNT_W-1:0] i_frame_gap,
  input  logic [CNT_W-1:0] i_timeout,
  input  logic             i_tx_fsm_busy,
  input  logic [RXC_W-1:0] i_rx_packet_count,
  output logic             o_tx_start,
  output logic             o_tx_use_lfsr,
  output logic             o_lfsr_seed_rst,
  output logic             o_rx_rst_waddr,
  output logic [15:0]      o_tx_payload_size,
  output logic [15:0]      o_tx_gap_count,
  output logic [31:0]      o_lfsr_seed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [2:0]       o_err_code,
  output logic [CNT_W-1:0] o_tx_sent,
  output logic [CNT_W-1:0] o_rx_seen
);

  localparam int unsigned PAY_W = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_WAIT_IDLE = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_END  = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;
  localparam logic [2:0] S_DRAIN     = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_START = 3'd1;
  localparam logic [2:0] ERR_END   = 3'd2;
  localparam logic [2:0] ERR_DRAIN = 3'd3;
  localparam logic [2:0] ERR_ABORT = 3'd4;

  logic [2:0]       state, state_nx;
  logic [2:0]       err_nx;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] num_q, gap_q, tmo_q, tmo_lim;
  logic [PAY_W-1:0] pmin_q, pmax_q, pstep_q, pay_nx;
  logic [PAY_W:0]   pay_sum;
  logic [RXC_W-1:0] rx_prev, rx_delta;
  logic             run_ok, active, tmo_hit, hs_done, frame_next;

  assign run_ok   = i_run && (state == S_IDLE || state == S_DONE);
  assign active   = (state != S_IDLE) && (state != S_DONE);
  assign tmo_lim  = (tmo_q == '0) ? '1 : tmo_q;
  assign tmo_hit  = (timer == tmo_lim - CNT_W'(1));
  assign hs_done  = (state == S_START) && i_tx_fsm_busy;
  assign rx_delta = i_rx_packet_count - rx_prev;

  // Next payload in 17 bits so that overflow past 0xFFFF also wraps to min.
  assign pay_sum = {1'b0, o_tx_payload_size} + {1'b0, pstep_q};
  assign pay_nx  = (pay_sum > {1'b0, pmax_q}) ? pmin_q : pay_sum[PAY_W-1:0];

  assign frame_next = (state == S_WAIT_END) &&
                      (state_nx == S_GAP || state_nx == S_START);

  // Next-state and error-code logic; abort overrides every other transition.
  always_comb begin
    state_nx = state;
    err_nx   = o_err_code;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_run) begin
          err_nx   = ERR_NONE;
          state_nx = (i_num_packets == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: state_nx = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!i_tx_fsm_busy) begin
          state_nx = S_START;
        end else if (tmo_hit) begin
          state_nx = S_DONE;
          err_nx   = ERR_START;
        end
      end
      S_START: begin
        if (i_tx_fsm_busy) begin
          state_nx = S_WAIT_END;
        end else if (tmo_hit) begin
          state_nx = S_DONE;
          err_nx   = ERR_START;
        end
      end
      S_WAIT_END: begin
        if (!i_tx_fsm_busy) begin
          if (o_tx_sent < num_q) state_nx = (gap_q == '0) ? S_START : S_GAP;
          else                   state_nx = S_DRAIN;
        end else if (tmo_hit) begin
          state_nx = S_DONE;
          err_nx   = ERR_END;
        end
      end
      S_GAP: begin
        if (timer == gap_q - CNT_W'(1)) state_nx = S_START;
      end
      S_DRAIN: begin
        if (o_rx_seen == num_q) begin
          state_nx = S_DONE;
        end else if (tmo_hit) begin
          state_nx = S_DONE;
          err_nx   = ERR_DRAIN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (active && i_abort) begin
      state_nx = S_DONE;
      err_nx   = ERR_ABORT;
    end
  end

  // State, per-state timer, configuration and registered outputs.
  always_ff @(posedge i_main_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= S_IDLE;
      timer             <= '0;
      num_q             <= '0;
      gap_q             <= '0;
      tmo_q             <= '0;
      pmin_q            <= '0;
      pmax_q            <= '0;
      pstep_q           <= '0;
      rx_prev           <= '0;
      o_tx_start        <= 1'b0;
      o_tx_use_lfsr     <= 1'b0;
      o_lfsr_seed_rst   <= 1'b0;
      o_rx_rst_waddr    <= 1'b0;
      o_tx_payload_size <= '0;
      o_tx_gap_count    <= '0;
      o_lfsr_seed       <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_err_code        <= '0;
      o_tx_sent         <= '0;
      o_rx_seen         <= '0;
    end else begin
      state           <= state_nx;
      timer           <= (state_nx != state) ? '0 : timer + CNT_W'(1);
      o_err_code      <= err_nx;
      o_busy          <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      o_done          <= (state_nx == S_DONE);
      o_pass          <= (state_nx == S_DONE) && (err_nx == ERR_NONE);
      o_tx_start      <= (state_nx == S_START);
      o_lfsr_seed_rst <= (state_nx == S_SETUP);
      o_rx_rst_waddr  <= (state_nx == S_SETUP);
      if (run_ok) begin
        num_q          <= i_num_packets;
        gap_q          <= i_frame_gap;
        tmo_q          <= i_timeout;
        pmin_q         <= i_payload_min;
        pmax_q         <= i_payload_max;
        pstep_q        <= i_payload_step;
        o_tx_use_lfsr  <= i_use_lfsr;
        o_lfsr_seed    <= i_lfsr_seed;
        o_tx_gap_count <= i_gap_count;
        o_tx_sent      <= '0;
        o_rx_seen      <= '0;
      end else begin
        // A completed handshake counts even when an abort wins the same cycle.
        if (hs_done) o_tx_sent <= o_tx_sent + CNT_W'(1);
        // SETUP takes the reference count; later states accumulate modular deltas.
        if (state == S_SETUP) begin
          rx_prev           <= i_rx_packet_count;
          o_tx_payload_size <= pmin_q;
        end else if (state != S_IDLE) begin
          rx_prev   <= i_rx_packet_count;
          o_rx_seen <= o_rx_seen + CNT_W'(rx_delta);
        end
        if (frame_next) o_tx_payload_size <= pay_nx;
      end
    end
  end

endmodule

// File: doc/eth_traffic_sequencer.md
# eth_traffic_sequencer

Controller that drives the TX side of `ethernet_interface_top` through an unattended burst test and checks the RX packet counter for loopback completion. It latches a test configuration and performs the `i_tx_start`/`o_tx_fsm_busy` handshake once per frame. Between frames it inserts a programmable gap and can sweep the payload size. It issues the LFSR seed reset and RX write-address reset before a run, then reports pass/fail with an error code.

## Interface
- `CNT_W`, 16: width of the packet-count, gap and timeout fields.
- `RXC_W`, 10: width of the core's RX packet counter.
- `i_main_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_run`  in  1  start pulse; accepted only in IDLE or DONE.
- `i_abort`  in  1  level; forces termination.
- `i_num_packets`  in  CNT_W  frames to send.
- `i_payload_min` / `i_payload_max` / `i_payload_step`  in  16 each  payload sweep settings.
- `i_use_lfsr`  in  1  LFSR payload enable.
- `i_lfsr_seed`  in  32  LFSR seed.
- `i_gap_count`  in  16  core inter-frame gap, passed through.
- `i_frame_gap`  in  CNT_W  idle cycles between frames.
- `i_timeout`  in  CNT_W  per-wait timeout in cycles; 0 = 65535.
- `i_tx_fsm_busy`  in  1  from core.
- `i_rx_packet_count`  in  RXC_W  from core.
- `o_tx_start`, `o_tx_use_lfsr`, `o_lfsr_seed_rst`, `o_rx_rst_waddr`  out  1  to core.
- `o_tx_payload_size`  out  16  to core.
- `o_tx_gap_count`  out  16  to core.
- `o_lfsr_seed`  out  32  to core.
- `o_busy`, `o_done`, `o_pass`  out  1  status.
- `o_err_code`  out  3  error code.
- `o_tx_sent`  out  CNT_W  frames sent.
- `o_rx_seen`  out  CNT_W  frames received.

## Operation
- **Latching on run.** An accepted `i_run` latches all `i_*` configuration for the whole run. It also clears `o_done`, `o_pass`, `o_err_code`, `o_tx_sent` and `o_rx_seen`.
- **States:** IDLE, SETUP, WAIT_IDLE, START, WAIT_END, GAP, DRAIN, DONE.
- **IDLE/DONE → SETUP** on `i_run`. If `i_num_packets` = 0, go directly to DONE with a pass.
- **SETUP** (1 cycle): `o_lfsr_seed_rst` = 1 and `o_rx_rst_waddr` = 1. Snapshot `i_rx_packet_count` as the reference count. Go to WAIT_IDLE.
- **WAIT_IDLE:** wait for `i_tx_fsm_busy` = 0, then go to START.
- **START:** hold `o_tx_start` = 1 until `i_tx_fsm_busy` = 1. Then drop `o_tx_start`, increment `o_tx_sent`, and go to WAIT_END.
- **WAIT_END:** wait for `i_tx_fsm_busy` = 0.
  - If `o_tx_sent` < N: advance the payload and go to GAP.
  - Otherwise go to DRAIN.
- **GAP:** count `i_frame_gap` cycles (0 = skip the state), then go to START.
- **DRAIN:** wait until `o_rx_seen` == N, then go to DONE.
- **Timeouts.** A per-state timer resets on every state entry. Expiry in WAIT_IDLE or START gives code 1. Expiry in WAIT_END gives code 2. Expiry in DRAIN gives code 3.
- **Abort.** `i_abort` in any non-IDLE, non-DONE state gives code 4.
- **Error exit.** Every error goes to DONE with `o_tx_start` deasserted.
- **DONE:** `o_done` = 1; `o_pass` = (`o_err_code` == 0). Both are held until the next accepted `i_run`.
- **Payload sweep.** The first frame uses `i_payload_min`.
  - The next payload is computed as min + k·step in 17-bit arithmetic.
  - If the 17-bit result > `i_payload_max`, it wraps to `i_payload_min`.
  - step = 0 gives a constant payload.
  - min > max gives a constant payload of min.
- **RX accounting.** Every cycle, add (`i_rx_packet_count` − prev) mod 2^RXC_W to `o_rx_seen`, then update prev. This tolerates wrap of the 10-bit counter. Accounting runs from SETUP through DONE.
- **Registered outputs.** `o_tx_use_lfsr`, `o_lfsr_seed` and `o_tx_gap_count` are registered copies of the latched configuration.
- **Payload output.** `o_tx_payload_size` updates only in WAIT_END or SETUP, so it is stable while `o_tx_start` is high.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE.
- **Reset mid-run.** A reset mid-run drops `o_tx_start` immediately and asynchronously.
- **Run start.** `i_run` at edge n makes `o_busy` = 1 and the state SETUP at n+1. START is entered at n+3 at the earliest.
- **Start handshake.** `o_tx_start` deasserts the cycle after `i_tx_fsm_busy` is first sampled high.
- **Start/busy overlap.** If busy is already high on START entry, `o_tx_start` is high for exactly 1 cycle.
- **Abort precedence.** `i_abort` and a handshake completing in the same cycle resolve as abort; `o_tx_sent` still counts that frame.
- **Run during a run.** `i_run` while `o_busy` = 1 is ignored.
- **Busy span.** `o_busy` is high from SETUP through DRAIN and drops in the cycle DONE is entered.

## Test plan
- **Basic pass.** N=2, min=max=10, `i_frame_gap`=5, with a core model in which busy rises 2 cycles after start, stays high 40 cycles, and increments the RX count 10 cycles later.
  - Expect two start pulses ≥5 idle cycles apart.
  - Expect `o_tx_sent` = `o_rx_seen` = 2, `o_pass` = 1, code 0.
- **Payload sweep.** min=10, max=30, step=10, N=5 → payload sequence 10, 20, 30, 10, 20.
- **Stuck busy.** Busy never rises, timeout=100 → DONE 100 cycles after START entry with code 1 and `o_tx_start` = 0.
- **RX wrap.** Preset the RX count to 1020 with N=8 → the count wraps to 4, `o_rx_seen` = 8, pass.
- **Dropped frame.** Drop one RX increment, N=3 → DRAIN timeout with code 3 and `o_rx_seen` = 2.
- **Abort and re-run.** Assert `i_abort` in GAP → code 4; then `i_run` with N=0 → immediate DONE with pass; asynchronous `i_rst` mid-START clears all outputs.
